// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte push into a FIFO, serialised LSB first on uart_txd (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          uart_txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           tx_ready_q, tx_ready_d;
    logic           tx_busy_q, tx_busy_d;
    logic           txd_q, txd_d;
    logic [2:0]     state_q, state_d;
    logic [BCW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           push_c, pop_c, tick_c;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    assign push_c = tx_valid && tx_ready_q;
    assign pop_c  = (state_q == S_IDLE) && (count_q != '0);
    assign tick_c = (baud_cnt_q == BCW'(CLKS_PER_BIT - 1));

    // FIFO pointers and occupancy; the extra count bit separates full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_c && !pop_c)      count_d = count_q + CW'(1);
        else if (pop_c && !push_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (push_c) mem_q[wr_ptr_q] <= tx_data;
    end

    // Frame sequencer; baud counter restarts on every state change
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + BCW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (pop_c) begin
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (tick_c) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_c) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_c) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Line level follows the current state one cycle later, from a flop
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_q;
`endif
            default:  txd_d = 1'b1;
        endcase
        tx_ready_d = (count_d != CW'(FIFO_DEPTH));
        tx_busy_d  = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            txd_q      <= 1'b1;
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            txd_q      <= txd_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_ready   = tx_ready_q;
    assign fifo_count = count_q;
    assign tx_busy    = tx_busy_q;
    assign uart_txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based frame model plus an independent line receiver.
// Uses a short bit period (16 clocks) to keep runs small; honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int unsigned TB_CLK_FREQ = 1000050;
    localparam int unsigned TB_BAUD     = 62500;
    localparam int DEPTH = 16;
    localparam int CPB   = int'(TB_CLK_FREQ / TB_BAUD);
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_ready;
    logic [CW-1:0] fifo_count;
    logic          tx_busy;
    logic          uart_txd;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .BAUD       (TB_BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .uart_txd   (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Reference model: byte queue plus a "frame time remaining" counter for the transmitter
    logic [7:0] mq[$];
    logic [7:0] m_log[$];
    int         m_busy = 0;
    logic [7:0] m_cur = 8'h00;
    logic       e_txd = 1'b1;
    logic       e_ready = 1'b1;
    logic       e_busy = 1'b0;
    int         e_count = 0;

    function automatic logic line_bit(int busy, logic [7:0] b);
        int idx;
        if (busy == 0) return 1'b1;
        idx = (FRAME - busy) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial begin : model
        int sz;
        bit do_pop, do_push;
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                mq.delete();
                m_busy = 0; e_txd = 1'b1; e_ready = 1'b1; e_busy = 1'b0; e_count = 0;
            end else begin
                sz      = mq.size();
                e_txd   = line_bit(m_busy, m_cur);
                do_pop  = (m_busy == 0) && (sz > 0);
                do_push = tx_valid && (sz != DEPTH);
                if (m_busy > 0) m_busy--;
                if (do_pop) begin
                    m_cur = mq.pop_front();
                    m_log.push_back(m_cur);
                    m_busy = FRAME;
                end
                if (do_push) mq.push_back(tx_data);
                e_count = mq.size();
                e_ready = (e_count != DEPTH);
                e_busy  = (m_busy != 0) || (e_count != 0);
            end
        end
    end

    // Line receiver: samples mid-bit, records byte, start cycle, parity and stop bits
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];
    logic       rx_par[$];

    initial begin : rx
        logic [7:0] b;
        logic prev;
        int t;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (prev && !uart_txd && sys_rst_n) begin
                t = cyc;
                repeat (CPB / 2) @(negedge sys_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sys_clk);
                    b[i] = uart_txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge sys_clk);
                rx_par.push_back(uart_txd);
`endif
                repeat (CPB) @(negedge sys_clk);
                rx_stop.push_back(uart_txd);
                rx_q.push_back(b);
                rx_t.push_back(t);
            end
            prev = uart_txd;
        end
    end

    task automatic clear_rx();
        rx_q.delete(); rx_t.delete(); rx_stop.delete(); rx_par.delete();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tx_valid  = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
                n_fails++;
                $display("FAIL reset_idle cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected 1/1/0/0",
                         k, uart_txd, tx_ready, tx_busy, fifo_count);
            end
        end
    endtask

    task automatic test_single_byte();
        int first_low, busy_cycles;
        first_low = -1;
        busy_cycles = 0;
        clear_rx();
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        for (int k = 0; k < FRAME + 40; k++) begin
            @(negedge sys_clk);
            tx_valid = 1'b0;
            if (first_low < 0 && uart_txd === 1'b0) first_low = k;
            if (tx_busy === 1'b1) busy_cycles++;
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL single cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        n_checks++;
        if (first_low != 2) begin
            n_fails++;
            $display("FAIL single_latency: start bit after %0d edges, expected 2", first_low);
        end
        n_checks++;
        if (busy_cycles != FRAME + 1) begin
            n_fails++;
            $display("FAIL single_busy_len: %0d cycles, expected %0d", busy_cycles, FRAME + 1);
        end
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
            n_fails++;
            $display("FAIL single_byte: %0d frames first=%h, expected 1 frame 11",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_burst_full();
        int max_cnt, gap;
        bit saw_not_ready;
        max_cnt = 0;
        saw_not_ready = 0;
        clear_rx();
        for (int k = 0; k < 20 + 17 * (FRAME + 1) + 40; k++) begin
            tx_valid = (k < 20);
            tx_data  = 8'(k);
            @(negedge sys_clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (tx_ready === 1'b0) saw_not_ready = 1;
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL burst cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        tx_valid = 1'b0;
        n_checks++;
        if (max_cnt != DEPTH || !saw_not_ready) begin
            n_fails++;
            $display("FAIL burst_full: max count %0d ready_dropped=%0d, expected %0d and 1",
                     max_cnt, saw_not_ready, DEPTH);
        end
        n_checks++;
        if (rx_q.size() != 17) begin
            n_fails++;
            $display("FAIL burst_frames: %0d frames, expected 17", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 17; i++) begin
            n_checks++;
            if (rx_q[i] !== 8'(i) || rx_stop[i] !== 1'b1) begin
                n_fails++;
                $display("FAIL burst_byte %0d: got %h stop %b, expected %h stop 1", i, rx_q[i], rx_stop[i], 8'(i));
            end
            if (i > 0) begin
                gap = rx_t[i] - rx_t[i-1];
                n_checks++;
                if (gap < FRAME || gap > FRAME + 1) begin
                    n_fails++;
                    $display("FAIL burst_gap %0d: %0d cycles, expected %0d..%0d", i, gap, FRAME, FRAME + 1);
                end
            end
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] b[5];
        bit found;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        clear_rx();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_data  = b[i];
            @(negedge sys_clk);
        end
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_count !== CW'(3)) begin
            n_fails++;
            $display("FAIL simul_setup_count: %0d, expected 3", fifo_count);
        end
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            if (m_busy == 0 && mq.size() > 0) found = 1;
            else begin
                @(negedge sys_clk);
                n_checks++;
                if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                    n_fails++;
                    $display("FAIL simul_wait cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                             k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
                end
            end
        end
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("FAIL simul_timeout: pop cycle not reached, expected within %0d cycles", 2 * FRAME);
        end
        tx_valid = 1'b1;
        tx_data  = b[4];
        @(negedge sys_clk);
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_count !== CW'(3)) begin
            n_fails++;
            $display("FAIL simul_count: %0d after push on pop cycle, expected 3", fifo_count);
        end
        for (int k = 0; k < 4 * (FRAME + 1) + 40; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL simul cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        n_checks++;
        if (rx_q.size() != 5) begin
            n_fails++;
            $display("FAIL simul_frames: %0d frames, expected 5", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            n_checks++;
            if (rx_q[i] !== b[i]) begin
                n_fails++;
                $display("FAIL simul_byte %0d: got %h, expected %h", i, rx_q[i], b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int low_cnt;
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'b1;
            tx_data  = (i == 0) ? 8'hA5 : 8'($urandom);
            @(negedge sys_clk);
        end
        tx_valid = 1'b0;
        repeat (5 * CPB + CPB / 2 - 3) @(negedge sys_clk);
        n_checks++;
        if (uart_txd !== 1'b0 || fifo_count !== CW'(5)) begin
            n_fails++;
            $display("FAIL midframe_setup: txd=%b count=%0d, expected 0 and 5", uart_txd, fifo_count);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
            n_fails++;
            $display("FAIL midframe_async: txd/ready/busy/count=%b/%b/%b/%0d, expected 1/1/0/0",
                     uart_txd, tx_ready, tx_busy, fifo_count);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        low_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) low_cnt++;
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL midframe_after cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        n_checks++;
        if (low_cnt != 0) begin
            n_fails++;
            $display("FAIL midframe_silence: line low for %0d cycles after reset, expected 0", low_cnt);
        end
    endtask

    task automatic test_random();
        clear_rx();
        m_log.delete();
        for (int k = 0; k < 4000 + 17 * (FRAME + 1) + 40; k++) begin
            if (k < 2000)      tx_valid = ($urandom_range(0, 99) < 25);
            else if (k < 4000) tx_valid = ($urandom_range(0, 99) < 1);
            else               tx_valid = 1'b0;
            tx_data = 8'($urandom);
            @(negedge sys_clk);
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL random cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        tx_valid = 1'b0;
        n_checks++;
        if (rx_q.size() != m_log.size() || tx_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL random_frames: %0d received busy=%b, expected %0d and 0",
                     rx_q.size(), tx_busy, m_log.size());
        end
        for (int i = 0; i < rx_q.size() && i < m_log.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== m_log[i]) begin
                n_fails++;
                $display("FAIL random_byte %0d: got %h, expected %h", i, rx_q[i], m_log[i]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        clear_rx();
        for (int k = 0; k < 2 * (FRAME + 1) + 40; k++) begin
            tx_valid = (k < 2);
            tx_data  = (k == 0) ? 8'h33 : 8'h31;
            @(negedge sys_clk);
            n_checks++;
            if ({uart_txd, tx_ready, tx_busy, fifo_count} !== {e_txd, e_ready, e_busy, CW'(e_count)}) begin
                n_fails++;
                $display("FAIL parity cycle %0d: txd/ready/busy/count=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         k, uart_txd, tx_ready, tx_busy, fifo_count, e_txd, e_ready, e_busy, e_count);
            end
        end
        tx_valid = 1'b0;
        n_checks++;
        if (rx_q.size() != 2 || rx_par.size() != 2) begin
            n_fails++;
            $display("FAIL parity_frames: %0d frames, expected 2", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] !== 8'h33 || rx_par[0] !== 1'b0 || rx_q[1] !== 8'h31 || rx_par[1] !== 1'b1) begin
                n_fails++;
                $display("FAIL parity_bits: %h/%b %h/%b, expected 33/0 31/1", rx_q[0], rx_par[0], rx_q[1], rx_par[1]);
            end
            n_checks++;
            if (rx_t[1] - rx_t[0] != 11 * CPB + 1) begin
                n_fails++;
                $display("FAIL parity_frame_len: %0d cycles start-to-start, expected %0d", rx_t[1] - rx_t[0], 11 * CPB + 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_burst_full();
        test_simul_push_pop();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before it");
        $fatal(1, "watchdog expired");
    end

endmodule
